input_debouncer: RTL and testbench



---
 rtl/dbnc_pkg.sv | 25 ++
 rtl/dbnc_channel.sv | 97 +++++++++
 rtl/input_debouncer.sv | 95 +++++++++
 tb/tb_input_debouncer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbnc_pkg.sv
// Shared constants and helpers for the input_debouncer slice.
// Optional build macro: DBNC_GLITCH_CNT_EN (adds the glitch_cnt output).
package dbnc_pkg;

  localparam int unsigned DBNC_PRESCALE_DEF = 1000;
  localparam int unsigned DBNC_STABLE_DEF   = 4;
  localparam int unsigned SYNC_STAGES       = 2;

  // A channel is STABLE while its counter is zero, PENDING otherwise.
  typedef enum logic {
    CH_STABLE  = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_e;

  // Stability counter width: clog2(STABLE_TICKS), never less than 1 bit.
  function automatic int unsigned dbnc_cnt_w(input int unsigned stable_ticks);
    return (stable_ticks <= 1) ? 1 : $clog2(stable_ticks);
  endfunction

  // Prescaler width: clog2(PRESCALE), never less than 1 bit.
  function automatic int unsigned dbnc_pre_w(input int unsigned prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/dbnc_channel.sv
// One debounce channel: 2-flop synchronizer, tick-sampled stability
// counter, registered debounced level and one-cycle rise/fall pulses.
// Optional build macro: DBNC_GLITCH_CNT_EN (exports o_reject).
module dbnc_channel
  import dbnc_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DBNC_STABLE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_sync,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
`ifdef DBNC_GLITCH_CNT_EN
  ,
  output logic o_reject
`endif
);

  localparam int unsigned   CW       = dbnc_cnt_w(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_db;
  logic                   r_rise;
  logic                   r_fall;

  ch_state_e              w_state;
  logic                   w_s2;
  logic                   w_diff;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   w_db_nxt;
  logic                   w_flip;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;

  assign w_s2    = r_sync[SYNC_STAGES-1];
  assign w_diff  = (w_s2 != r_db);
  assign w_state = (r_cnt == '0) ? CH_STABLE : CH_PENDING;

  // State register: synchronizer chain, counter, level and pulse flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_db   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt  <= w_cnt_nxt;
      r_db   <= w_db_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  // Next state: only ticks move the counter; a full run of differing
  // ticks flips the level, a matching tick while pending rejects.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_db_nxt  = r_db;
    w_flip    = 1'b0;
    if (i_tick) begin
      if (w_diff) begin
        if (r_cnt == CNT_LAST) begin
          w_flip    = 1'b1;
          w_db_nxt  = ~r_db;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end else if (w_state == CH_PENDING) begin
        w_cnt_nxt = '0;
      end
    end
  end

  // Outputs: pulse direction follows the level being left.
  always_comb begin
    w_rise_nxt = w_flip & ~r_db;
    w_fall_nxt = w_flip &  r_db;
`ifdef DBNC_GLITCH_CNT_EN
    o_reject   = i_tick & ~w_diff & (w_state == CH_PENDING);
`endif
  end

  assign o_sync = w_s2;
  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel input debouncer: shared sample-tick prescaler, one
// dbnc_channel per input, registered all-settled flag.
// Optional build macro: DBNC_GLITCH_CNT_EN (adds saturating glitch_cnt).
module input_debouncer
  import dbnc_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned PRESCALE     = DBNC_PRESCALE_DEF,
  parameter int unsigned STABLE_TICKS = DBNC_STABLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] raw_in,
  output logic [NUM_CH-1:0] db_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              settled
`ifdef DBNC_GLITCH_CNT_EN
  ,
  output logic [7:0]        glitch_cnt
`endif
);

  localparam int unsigned   PW      = dbnc_pre_w(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]     r_pre;
  logic              r_settled;
  logic              w_tick;
  logic [NUM_CH-1:0] w_sync;
  logic [NUM_CH-1:0] w_db;
  logic [NUM_CH-1:0] w_match;

  assign w_tick  = (r_pre == PS_LAST);
  assign w_match = ~(w_sync ^ w_db);

  // Sample-tick prescaler: counts 0..PRESCALE-1 and wraps on the tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  // Settled flag: every synchronized input agrees with its debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_settled <= 1'b0;
    end else begin
      r_settled <= &w_match;
    end
  end

`ifdef DBNC_GLITCH_CNT_EN
  logic [NUM_CH-1:0] w_reject;
  logic [7:0]        r_glitch;

  // Glitch counter: one count per tick with any rejection, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_glitch <= '0;
    end else if ((|w_reject) && (r_glitch != '1)) begin
      r_glitch <= r_glitch + 1'b1;
    end
  end

  assign glitch_cnt = r_glitch;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    dbnc_channel #(
      .STABLE_TICKS (STABLE_TICKS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_tick   (w_tick),
      .i_raw    (raw_in[g]),
      .o_sync   (w_sync[g]),
      .o_db     (w_db[g]),
      .o_rise   (rise_pulse[g]),
      .o_fall   (fall_pulse[g])
`ifdef DBNC_GLITCH_CNT_EN
      ,
      .o_reject (w_reject[g])
`endif
    );
  end

  assign db_out  = w_db;
  assign settled = r_settled;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (PRESCALE=4, STABLE_TICKS=3) plus a
// second instance with PRESCALE=1, STABLE_TICKS=1.
// Optional build macro: DBNC_GLITCH_CNT_EN (checks glitch_cnt).
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw_in;
  logic [2:0] db_out;
  logic [2:0] rise_pulse;
  logic [2:0] fall_pulse;
  logic       settled;

  logic [0:0] raw2;
  logic [0:0] db2;
  logic [0:0] rise2;
  logic [0:0] fall2;
  logic       settled2;

`ifdef DBNC_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
  logic [7:0] glitch_cnt2;
`endif

  int errors = 0;
  int checks = 0;
  int rc [3] = '{0, 0, 0};
  int fc [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  input_debouncer #(
    .NUM_CH       (3),
    .PRESCALE     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .settled    (settled)
`ifdef DBNC_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt)
`endif
  );

  input_debouncer #(
    .NUM_CH       (1),
    .PRESCALE     (1),
    .STABLE_TICKS (1)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw2),
    .db_out     (db2),
    .rise_pulse (rise2),
    .fall_pulse (fall2),
    .settled    (settled2)
`ifdef DBNC_GLITCH_CNT_EN
    ,
    .glitch_cnt (glitch_cnt2)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Pulse monitor: every pulse must coincide with a db_out edge of the
  // matching direction, and reset edges never pulse.
  logic       mon_rst;
  logic [2:0] prev_db = '0;
  logic [2:0] exp_r;
  logic [2:0] exp_f;
  always @(posedge clk) begin
    mon_rst = rst;
    #1;
    exp_r = mon_rst ? 3'b000 : (db_out & ~prev_db);
    exp_f = mon_rst ? 3'b000 : (~db_out & prev_db);
    checks++;
    if ((rise_pulse !== exp_r) || (fall_pulse !== exp_f)) begin
      errors++;
      $display("FAIL pulse_vs_edge: rise=%b fall=%b expected rise=%b fall=%b",
               rise_pulse, fall_pulse, exp_r, exp_f);
    end
    for (int k = 0; k < 3; k++) begin
      if (rise_pulse[k]) rc[k]++;
      if (fall_pulse[k]) fc[k]++;
    end
    prev_db = db_out;
  end

  typedef struct {
    logic [2:0]  raw;
    int unsigned wait_cyc;
    logic [2:0]  exp_db;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [2:0] prev;
    int rc0 [3];
    int fc0 [3];
    int n;
    logic got;
    logic int_ok;
`ifdef DBNC_GLITCH_CNT_EN
    logic [7:0] g0;
`endif

    tbl[0] = '{3'b000, 20, 3'b000};
    tbl[1] = '{3'b001, 20, 3'b001};
    tbl[2] = '{3'b011, 20, 3'b011};
    tbl[3] = '{3'b110, 20, 3'b110};
    tbl[4] = '{3'b101, 20, 3'b101};
    tbl[5] = '{3'b000, 20, 3'b000};

    rst    = 1'b1;
    raw_in = 3'b000;
    raw2   = 1'b0;

    // Reset state
    repeat (3) begin
      cyc();
      chk("rst_db", 32'(db_out), 32'h0);
      chk("rst_settled", 32'(settled), 32'h0);
    end
`ifdef DBNC_GLITCH_CNT_EN
    chk("rst_glitch", 32'(glitch_cnt), 32'h0);
`endif
    rst = 1'b0;
    cyc();
    cyc();
    chk("settled_after_rst", 32'(settled), 32'h1);

    // Steady-state vectors: level, settled and exact pulse counts
    prev = 3'b000;
    for (int unsigned v = 0; v < 6; v++) begin
      for (int k = 0; k < 3; k++) begin
        rc0[k] = rc[k];
        fc0[k] = fc[k];
      end
      raw_in = tbl[v].raw;
      repeat (tbl[v].wait_cyc) cyc();
      chk("tbl_db", 32'(db_out), 32'(tbl[v].exp_db));
      chk("tbl_settled", 32'(settled), 32'h1);
      for (int k = 0; k < 3; k++) begin
        chk("tbl_rise_cnt", 32'(rc[k] - rc0[k]), 32'(tbl[v].exp_db[k] & ~prev[k]));
        chk("tbl_fall_cnt", 32'(fc[k] - fc0[k]), 32'(~tbl[v].exp_db[k] & prev[k]));
      end
      prev = tbl[v].exp_db;
    end

    // Single rising edge latency window, settled low meanwhile
    raw_in = 3'b001;
    n = 0;
    got = 1'b0;
    int_ok = 1'b1;
    while ((n < 30) && !got) begin
      cyc();
      n++;
      if (db_out[0]) got = 1'b1;
      else if ((n >= 3) && settled) int_ok = 1'b0;
    end
    chk("edge_seen", 32'(got), 32'h1);
    chk("edge_latency_in_11_14", 32'((n >= 11) && (n <= 14)), 32'h1);
    chk("edge_rise_pulse", 32'(rise_pulse), 32'h1);
    chk("edge_settled_low", 32'(int_ok), 32'h1);
    cyc();
    chk("edge_rise_one_clk", 32'(rise_pulse), 32'h0);
    chk("edge_settled_back", 32'(settled), 32'h1);

    // Short glitch on channel 1 is rejected
    for (int k = 0; k < 3; k++) rc0[k] = rc[k];
`ifdef DBNC_GLITCH_CNT_EN
    g0 = glitch_cnt;
`endif
    raw_in = 3'b011;
    repeat (5) cyc();
    raw_in = 3'b001;
    repeat (20) cyc();
    chk("glitch_db", 32'(db_out), 32'h1);
    chk("glitch_no_rise", 32'(rc[1] - rc0[1]), 32'h0);
    chk("glitch_settled", 32'(settled), 32'h1);
`ifdef DBNC_GLITCH_CNT_EN
    chk("glitch_cnt_delta", 32'(glitch_cnt - g0), 32'h1);
`endif

    // All channels together, up then down
    raw_in = 3'b000;
    repeat (20) cyc();
    chk("all_pre_db", 32'(db_out), 32'h0);
    raw_in = 3'b111;
    n = 0;
    while ((n < 30) && (db_out == 3'b000)) begin
      cyc();
      n++;
    end
    chk("all_rise_db", 32'(db_out), 32'h7);
    chk("all_rise_pulse", 32'(rise_pulse), 32'h7);
    repeat (20) cyc();
    raw_in = 3'b000;
    n = 0;
    while ((n < 30) && (db_out == 3'b111)) begin
      cyc();
      n++;
    end
    chk("all_fall_db", 32'(db_out), 32'h0);
    chk("all_fall_pulse", 32'(fall_pulse), 32'h7);
    repeat (20) cyc();

    // Reset while channel 2 is pending discards the transition
    raw_in = 3'b100;
    repeat (10) cyc();
    chk("pend_db", 32'(db_out), 32'h0);
    chk("pend_settled", 32'(settled), 32'h0);
    rst = 1'b1;
    cyc();
    chk("midrst_db", 32'(db_out), 32'h0);
    chk("midrst_pulses", 32'({rise_pulse, fall_pulse}), 32'h0);
    chk("midrst_settled", 32'(settled), 32'h0);
    rst = 1'b0;
    n = 0;
    while ((n < 30) && !db_out[2]) begin
      cyc();
      n++;
    end
    chk("postrst_latency_in_11_14", 32'((n >= 11) && (n <= 14)), 32'h1);
    chk("postrst_rise", 32'(rise_pulse), 32'h4);
    raw_in = 3'b000;
    repeat (20) cyc();

    // PRESCALE=1, STABLE_TICKS=1: one-clk raw pulse shows up 3 clk later
    raw2 = 1'b1;
    cyc();
    raw2 = 1'b0;
    n = 1;
    while ((n < 10) && !db2[0]) begin
      cyc();
      n++;
    end
    chk("fast_latency", 32'(n), 32'd3);
    chk("fast_rise", 32'({rise2, fall2}), 32'h2);
    cyc();
    chk("fast_db_back", 32'(db2), 32'h0);
    chk("fast_fall", 32'({rise2, fall2}), 32'h1);
    cyc();
    chk("fast_quiet", 32'({rise2, fall2}), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
